dm_arbiter: RTL

- Sequencing controller and two-port arbiter in front of the single-port word-organised data memory.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port.
- Grants one request at a time using round-robin, then sequences the memory: word store is a single write; byte/half store is read-modify-write; loads are a read followed by extract and zero/sign-extend.
- Memory side: synchronous read (1-cycle latency), synchronous write.

---
 rtl/dm_arbiter_if.sv | 45 ++++
 rtl/dm_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_arbiter_if
// Bus bundle between the two data-memory requesters, the dm_arbiter and the
// single-port word-organised data memory.
//   Port 0 (pipeline MEM stage) and port 1 (loader/debug):
//     reqN, weN, sizeN, sextN, addrN, wdataN  -> request side
//     ackN, rdataN, errN                      <- completion side
//   Memory side: mem_addr, mem_re, mem_we, mem_wdata (out of arbiter),
//                mem_rdata (into arbiter, valid the cycle after mem_re).
//   busy: arbiter is sequencing an access.
// Modports: slave = arbiter view, master = requester/memory-model view.
// ---------------------------------------------------------------------------
interface dm_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              req0,   req1;
  logic              we0,    we1;
  logic [1:0]        size0,  size1;
  logic              sext0,  sext1;
  logic [31:0]       addr0,  addr1;
  logic [31:0]       wdata0, wdata1;
  logic              ack0,   ack1;
  logic [31:0]       rdata0, rdata1;
  logic              err0,   err1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, size0, size1, sext0, sext1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_re, mem_we, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, size0, size1, sext0, sext1,
           addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
           mem_addr, mem_re, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-port,
// word-organised data memory (synchronous read, 1-cycle latency).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : dm_arbiter_if.slave (requests, acks/rdata/err, memory strobes)
// Word store = one write; byte/half store = read-modify-write; loads = read
// then lane extract with zero/sign extension.
// Optional macro DM_ALIGN_CHECK_EN: misaligned half/word accesses are
// completed at grant with err=1 and no memory access. When undefined the
// err outputs are constant 0 and low address bits below the size are ignored.
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic       clk,
  input  logic       reset,
  dm_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_MERGE, S_LD} state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_ack0, r_ack1, r_err0, r_err1;
  logic [31:0]       r_rdata0, r_rdata1;
  logic              r_mem_re, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  // Held copy of the granted request
  logic              r_port, r_we, r_sext;
  logic [1:0]        r_size;
  logic [1:0]        r_alo;
  logic [31:0]       r_wdata;

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  alo);
    logic [31:0] m;
    m = word;
    if (size == 2'd0) begin
      case (alo)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (size == 2'd1) begin
      if (alo[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sext,
                                               input logic [1:0]  alo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (alo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = alo[1] ? word[31:16] : word[15:0];
    if (size == 2'd0)      r = {{24{sext & b[7]}}, b};
    else if (size == 2'd1) r = {{16{sext & h[15]}}, h};
    else                   r = word;
    return r;
  endfunction

  // A port whose ack is high this cycle is still holding the request it
  // just completed, so it must not be accepted again yet.
  logic w_elig0, w_elig1, w_gnt_valid, w_gnt_port;
  assign w_elig0     = bus.req0 & ~r_ack0;
  assign w_elig1     = bus.req1 & ~r_ack1;
  assign w_gnt_valid = (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_gnt_port  = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

  logic        w_we, w_sext, w_misalign, w_done;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_merge, w_load;
  assign w_we    = w_gnt_port ? bus.we1    : bus.we0;
  assign w_size  = w_gnt_port ? bus.size1  : bus.size0;
  assign w_sext  = w_gnt_port ? bus.sext1  : bus.sext0;
  assign w_addr  = w_gnt_port ? bus.addr1  : bus.addr0;
  assign w_wdata = w_gnt_port ? bus.wdata1 : bus.wdata0;

`ifdef DM_ALIGN_CHECK_EN
  assign w_misalign = ((w_size == 2'd1) & w_addr[0]) | (w_size[1] & (|w_addr[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  // Address bits above the memory's word index are ignored.
  logic w_unused;
  assign w_unused = ^w_addr[31:ADDR_W+2];

  assign w_merge = merge_lane(bus.mem_rdata, r_wdata, r_size, r_alo);
  assign w_load  = load_extract(bus.mem_rdata, r_size, r_sext, r_alo);
  assign w_done  = (r_state == S_WR) | (r_state == S_MERGE) | (r_state == S_LD);

  always_ff @(posedge clk) begin
    if (w_gnt_valid) begin
      r_port  <= w_gnt_port;
      r_we    <= w_we;
      r_size  <= w_size;
      r_sext  <= w_sext;
      r_alo   <= w_addr[1:0];
      r_wdata <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_valid) begin
            r_last_grant <= w_gnt_port;
            r_mem_addr   <= w_addr[ADDR_W+1:2];
            if (w_misalign) begin
              // Complete immediately with err; state stays IDLE.
              if (w_gnt_port) begin
                r_ack1 <= 1'b1;
                r_err1 <= 1'b1;
              end else begin
                r_ack0 <= 1'b1;
                r_err0 <= 1'b1;
              end
            end else if (w_we && w_size[1]) begin
              r_state     <= S_WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_wdata;
            end else begin
              r_state  <= S_RD;
              r_mem_re <= 1'b1;
            end
          end
        end
        S_WR: r_state <= S_IDLE;
        S_RD: begin
          if (r_we) begin
            r_state  <= S_MERGE;
            r_mem_we <= 1'b1;
          end else begin
            r_state <= S_LD;
          end
        end
        S_MERGE: begin
          r_state     <= S_IDLE;
          r_mem_wdata <= w_merge;
        end
        S_LD: begin
          r_state <= S_IDLE;
          if (r_port) r_rdata1 <= w_load;
          else        r_rdata0 <= w_load;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_done) begin
        if (r_port) begin
          r_ack1 <= 1'b1;
          r_err1 <= 1'b0;
        end else begin
          r_ack0 <= 1'b1;
          r_err0 <= 1'b0;
        end
      end
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  // Without the alignment check the err registers can only ever hold 0.
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  // The merged word depends on mem_rdata, which only arrives in MERGE.
  assign bus.mem_wdata = (r_state == S_MERGE) ? w_merge : r_mem_wdata;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
